// File: rtl/store_sequencer.sv
// store_sequencer: handshaked word/half/byte store controller with read-modify-write for sub-word sizes
module store_sequencer #(
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  store_type,
    input  logic [31:0] addr,
    input  logic [31:0] B_out,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        err
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_addr;
    logic [31:0]      r_data;
    logic [1:0]       r_type;
    logic             r_err;
    logic             w_accept;
    logic             w_last;

    assign w_accept = (r_state == IDLE) && start;
    assign w_last   = (r_state == READ) && (r_cnt == CNT_W'(MEM_LAT - 1));

    // state register plus captured request; sub-word merge lands in r_data on the last read edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_type  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr <= addr;
                r_data <= B_out;
                r_type <= store_type;
                r_err  <= (store_type == 2'b00);
                r_cnt  <= '0;
            end else if (r_state == READ) begin
                r_cnt <= r_cnt + 1'b1;
                if (w_last)
                    r_data <= (r_type == 2'b10) ? {mem_rdata[31:16], r_data[15:0]}
                                                : {mem_rdata[31:8], r_data[7:0]};
            end
        end
    end

    // next-state decode; word skips the read, illegal goes straight to completion
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  w_next = !start                 ? IDLE  :
                            (store_type == 2'b01)  ? WRITE :
                            (store_type == 2'b00)  ? DONE  : READ;
            READ:  w_next = w_last ? WRITE : READ;
            WRITE: w_next = DONE;
            DONE:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign mem_addr  = r_addr;
    assign mem_wdata = r_data;
    assign mem_rd    = (r_state == READ);
    assign mem_wr    = (r_state == WRITE);
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign err       = (r_state == DONE) && r_err;
endmodule

// File: tb/tb_store_sequencer.sv
// tb_store_sequencer: directed vectors against MEM_LAT=1 and MEM_LAT=3 instances side by side
module tb_store_sequencer;
    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             start = 1'b0;
    logic [1:0]       store_type = 2'b00;
    logic [31:0]      addr = '0;
    logic [31:0]      B_out = '0;
    logic [31:0]      cur_rdata = '0;
    logic [1:0][31:0] rdata, maddr, wdata;
    logic [1:0]       rd, wr, busy, done, err;
    logic [3:0]       rc0 = '0;
    logic [3:0]       rc1 = '0;
    int               checks = 0;
    int               errors = 0;

    always #5 clk = ~clk;

    store_sequencer #(.MEM_LAT(LAT0), .CNT_W(4)) dut0 (
        .clk(clk), .reset_n(reset_n), .start(start), .store_type(store_type),
        .addr(addr), .B_out(B_out), .mem_rdata(rdata[0]), .mem_addr(maddr[0]),
        .mem_rd(rd[0]), .mem_wr(wr[0]), .mem_wdata(wdata[0]), .busy(busy[0]),
        .done(done[0]), .err(err[0]));

    store_sequencer #(.MEM_LAT(LAT1), .CNT_W(4)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start), .store_type(store_type),
        .addr(addr), .B_out(B_out), .mem_rdata(rdata[1]), .mem_addr(maddr[1]),
        .mem_rd(rd[1]), .mem_wr(wr[1]), .mem_wdata(wdata[1]), .busy(busy[1]),
        .done(done[1]), .err(err[1]));

    // memory model: read data is only valid on the MEM_LAT-th consecutive read cycle
    always @(posedge clk) begin
        rc0 <= rd[0] ? rc0 + 4'd1 : 4'd0;
        rc1 <= rd[1] ? rc1 + 4'd1 : 4'd0;
    end
    assign rdata[0] = (rd[0] && rc0 == 4'(LAT0 - 1)) ? cur_rdata : 32'hBAD0_BAD0;
    assign rdata[1] = (rd[1] && rc1 == 4'(LAT1 - 1)) ? cur_rdata : 32'hBAD0_BAD0;

    typedef struct {
        logic [1:0]  t;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [31:0] wd;
        logic        e;
    } vec_t;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic chk_idle(input string n);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s d%0d ctrl", n, d), {27'd0, rd[d], wr[d], busy[d], done[d], err[d]}, 32'd0);
            chk($sformatf("%s d%0d mem_addr", n, d), maddr[d], 32'd0);
            chk($sformatf("%s d%0d mem_wdata", n, d), wdata[d], 32'd0);
        end
    endtask

    task automatic run_vec(input int i, input vec_t v);
        int dk[2], rdc[2], wrc[2], bad[2], edk[2], erd[2];
        logic [31:0] wv[2], av[2];
        logic ev[2];
        for (int d = 0; d < 2; d++) begin
            dk[d] = 0; rdc[d] = 0; wrc[d] = 0; bad[d] = 0;
            wv[d] = 'x; av[d] = 'x; ev[d] = 1'bx;
            edk[d] = (v.t == 2'b01) ? 2 : (v.t == 2'b00) ? 1 : ((d == 0) ? LAT0 : LAT1) + 2;
            erd[d] = (v.t[1]) ? ((d == 0) ? LAT0 : LAT1) : 0;
        end
        start = 1'b1; store_type = v.t; addr = v.a; B_out = v.b; cur_rdata = v.r;
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0;
                B_out = 32'h5A5A_5A5A;
                addr = 32'h0BAD_0000;
            end
            for (int d = 0; d < 2; d++) begin
                if (rd[d]) rdc[d]++;
                if (wr[d]) begin wrc[d]++; wv[d] = wdata[d]; end
                if (rd[d] && wr[d]) bad[d]++;
                if (busy[d] != (k <= edk[d])) bad[d]++;
                if (done[d]) begin dk[d] = k; ev[d] = err[d]; av[d] = maddr[d]; end
            end
        end
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("v%0d d%0d done_cycle", i, d), dk[d], edk[d]);
            chk($sformatf("v%0d d%0d rd_cycles", i, d), rdc[d], erd[d]);
            chk($sformatf("v%0d d%0d wr_cycles", i, d), wrc[d], (v.t == 2'b00) ? 0 : 1);
            chk($sformatf("v%0d d%0d err", i, d), {31'd0, ev[d]}, {31'd0, v.e});
            chk($sformatf("v%0d d%0d mem_addr", i, d), av[d], v.a);
            chk($sformatf("v%0d d%0d busy/overlap", i, d), bad[d], 0);
            if (v.t != 2'b00) chk($sformatf("v%0d d%0d mem_wdata", i, d), wv[d], v.wd);
        end
    endtask

    initial begin
        vec_t vt[7];
        int wrn[2], rdn[2];
        logic [9:0] wm[2], dm[2], bm[2];
        vt[0] = '{2'b01, 32'h0000_0040, 32'hDEAD_BEEF, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0};
        vt[1] = '{2'b10, 32'h0000_1002, 32'hAAAA_5566, 32'h1122_3344, 32'h1122_5566, 1'b0};
        vt[2] = '{2'b11, 32'h0000_2003, 32'h0000_00F0, 32'h1122_3344, 32'h1122_33F0, 1'b0};
        vt[3] = '{2'b00, 32'h0000_3000, 32'h5555_5555, 32'h1122_3344, 32'h0000_0000, 1'b1};
        vt[4] = '{2'b11, 32'h0000_4001, 32'hFFFF_FF01, 32'hA5A5_A5A5, 32'hA5A5_A501, 1'b0};
        vt[5] = '{2'b10, 32'h0000_5000, 32'h0000_FFFF, 32'h8765_4321, 32'h8765_FFFF, 1'b0};
        vt[6] = '{2'b01, 32'hFFFF_FFFC, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0};

        repeat (3) @(negedge clk);
        chk_idle("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // reset asserted in the 2nd READ cycle of a MEM_LAT=3 half store
        start = 1'b1; store_type = 2'b10; addr = 32'h0000_0500; B_out = 32'h1234_5678; cur_rdata = 32'h1122_3344;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("midread in_read", {31'd0, rd[1]}, 32'd1);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1 chk_idle("midread async");
        wrn = '{0, 0}; rdn = '{0, 0};
        repeat (3) @(negedge clk) for (int d = 0; d < 2; d++) begin wrn[d] += wr[d]; rdn[d] += rd[d]; end
        reset_n = 1'b1;
        repeat (4) @(negedge clk) for (int d = 0; d < 2; d++) begin wrn[d] += wr[d]; rdn[d] += rd[d]; end
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("midread d%0d no_wr", d), wrn[d], 0);
            chk($sformatf("midread d%0d no_rd", d), rdn[d], 0);
        end

        for (int i = 0; i < 7; i++) run_vec(i, vt[i]);

        // start held high: word stores every 3 cycles
        start = 1'b1; store_type = 2'b01; addr = 32'h0000_0700; B_out = 32'hCAFE_F00D;
        wm = '{10'd0, 10'd0}; dm = '{10'd0, 10'd0}; bm = '{10'd0, 10'd0};
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                wm[d][k] = wr[d];
                dm[d][k] = done[d];
                bm[d][k] = busy[d];
            end
        end
        start = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("b2b d%0d wr_mask", d), {22'd0, wm[d]}, 32'h092);
            chk($sformatf("b2b d%0d done_mask", d), {22'd0, dm[d]}, 32'h124);
            chk($sformatf("b2b d%0d busy_mask", d), {22'd0, bm[d]}, 32'h1B6);
            chk($sformatf("b2b d%0d wdata", d), wdata[d], 32'hCAFE_F00D);
        end
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
